// File: rtl/toy_pack.sv
// Shared types and constants for the icache downstream memory path.
//   ADDR_WIDTH / MSHR_ID_WIDTH / BEAT_WIDTH : request and data widths
//   rxdat_pld_t : returned data beat {data, txnid, beat, last}
//   mem_req_t   : queued read request {addr, entry_id}
//   gen_beat    : deterministic line data, word i of beat k = addr + k*words + i
package toy_pack;

  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned MSHR_ID_WIDTH  = 4;
  localparam int unsigned BEAT_WIDTH     = 256;
  localparam int unsigned BEAT_IDX_WIDTH = 8;
  localparam int unsigned WORDS_PER_BEAT = BEAT_WIDTH / 32;

  typedef struct packed {
    logic [BEAT_WIDTH-1:0]     data;
    logic [MSHR_ID_WIDTH-1:0]  txnid;
    logic [BEAT_IDX_WIDTH-1:0] beat;
    logic                      last;
  } rxdat_pld_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]    addr;
    logic [MSHR_ID_WIDTH-1:0] entry_id;
  } mem_req_t;

  function automatic logic [BEAT_WIDTH-1:0] gen_beat(input logic [ADDR_WIDTH-1:0]     addr,
                                                     input logic [BEAT_IDX_WIDTH-1:0] k);
    logic [BEAT_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WORDS_PER_BEAT; i++) begin
      r[i*32 +: 32] = addr[31:0] + 32'(k) * 32'(WORDS_PER_BEAT) + 32'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// Synchronous FIFO holding outstanding read requests.
//   clk, rst        : clock, synchronous active-high reset
//   push, push_data : enqueue (ignored when full)
//   pop             : dequeue head (ignored when empty)
//   full, empty     : status from the registered occupancy
//   head            : entry at the read pointer
//   rptr, wptr      : pointers, exported so the parent can keep per-entry state
//   count           : occupancy, 0..DEPTH
module mem_rsp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH)-1:0]   rptr,
  output logic [$clog2(DEPTH)-1:0]   wptr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rptr_q, wptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rptr_q];
  assign rptr    = rptr_q;
  assign wptr    = wptr_q;
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/downstream_mem_responder.sv
// Behavioural downstream memory: accepts icache line reads, waits LATENCY cycles, then
// returns BEATS data beats per line in acceptance order.
//   clk, rst                          : clock, synchronous active-high reset
//   downstream_txreq_vld/rdy/pld      : line read request (address)
//   downstream_txreq_entry_id         : requester tag, echoed as txnid
//   downstream_rxdat_vld/rdy/pld      : returned data beats
module downstream_mem_responder
  import toy_pack::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 8,
  parameter int unsigned BEATS   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     downstream_txreq_vld,
  output logic                     downstream_txreq_rdy,
  input  logic [ADDR_WIDTH-1:0]    downstream_txreq_pld,
  input  logic [MSHR_ID_WIDTH-1:0] downstream_txreq_entry_id,
  output logic                     downstream_rxdat_vld,
  input  logic                     downstream_rxdat_rdy,
  output rxdat_pld_t               downstream_rxdat_pld
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e        state_q;
  logic [BW-1:0] beat_q;
  logic [7:0]    cnt_q [DEPTH];

  logic          push, pop, full, empty, last;
  logic          head_rdy, next_rdy;
  logic [PW-1:0] rptr, wptr, rptr_nxt;
  logic [CW-1:0] count;
  mem_req_t      req_in, head;

  assign req_in = '{addr: downstream_txreq_pld, entry_id: downstream_txreq_entry_id};

  mem_rsp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(mem_req_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (req_in),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head),
    .rptr      (rptr),
    .wptr      (wptr),
    .count     (count)
  );

  // No pop bypass: a full FIFO refuses requests even in the cycle it pops.
  assign downstream_txreq_rdy = ~rst & ~full;
  assign push                 = downstream_txreq_vld & downstream_txreq_rdy;

  assign downstream_rxdat_vld = ~rst & (state_q == StSend);
  assign last                 = (beat_q == BW'(BEATS - 1));
  assign pop                  = downstream_rxdat_vld & downstream_rxdat_rdy & last;

  // A countdown of 1 reaches 0 at this edge, so the registered FSM can enter SEND
  // exactly when the entry becomes due.
  assign rptr_nxt = rptr + PW'(1);
  assign head_rdy = ~empty & (cnt_q[rptr] <= 8'd1);
  assign next_rdy = (count > CW'(1)) & (cnt_q[rptr_nxt] <= 8'd1);

  // Countdowns are indexed by FIFO slot; stale slots just sit at 0 until reloaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - 8'd1;
      end
      if (push) cnt_q[wptr] <= 8'(LATENCY);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      beat_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (head_rdy) state_q <= StSend;
        end
        StSend: begin
          if (downstream_rxdat_rdy) begin
            if (last) begin
              beat_q <= '0;
              if (!next_rdy) state_q <= StIdle;
            end else begin
              beat_q <= beat_q + BW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Payload is a pure function of head entry and beat counter, so it holds across stalls.
  always_comb begin
    downstream_rxdat_pld = '0;
    if (downstream_rxdat_vld) begin
      downstream_rxdat_pld.data  = gen_beat(head.addr, BEAT_IDX_WIDTH'(beat_q));
      downstream_rxdat_pld.txnid = head.entry_id;
      downstream_rxdat_pld.beat  = BEAT_IDX_WIDTH'(beat_q);
      downstream_rxdat_pld.last  = last;
    end
  end

endmodule

// File: tb/tb_downstream_mem_responder.sv
module tb_downstream_mem_responder;
  import toy_pack::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned LATENCY = 8;
  localparam int unsigned BEATS   = 2;

  typedef struct packed {
    logic [255:0] data;
    logic [3:0]   id;
    logic [7:0]   beat;
    logic         last;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     txreq_vld = 1'b0;
  logic                     txreq_rdy;
  logic [ADDR_WIDTH-1:0]    txreq_pld = '0;
  logic [MSHR_ID_WIDTH-1:0] txreq_id = '0;
  logic                     rxdat_vld;
  logic                     rxdat_rdy = 1'b0;
  rxdat_pld_t               rxdat_pld;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   hs_cyc[$];
  bit   watch5 = 1'b0;
  int   n5 = 0;
  bit   prev_stall = 1'b0;
  rxdat_pld_t prev_pld;

  downstream_mem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY),
    .BEATS   (BEATS)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .downstream_txreq_vld      (txreq_vld),
    .downstream_txreq_rdy      (txreq_rdy),
    .downstream_txreq_pld      (txreq_pld),
    .downstream_txreq_entry_id (txreq_id),
    .downstream_rxdat_vld      (rxdat_vld),
    .downstream_rxdat_rdy      (rxdat_rdy),
    .downstream_rxdat_pld      (rxdat_pld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] exp_data(input logic [31:0] addr, input int k);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = addr + 32'(k * 8 + i);
    return r;
  endfunction

  task automatic push_exp(input logic [31:0] addr, input logic [3:0] id);
    for (int k = 0; k < BEATS; k++) begin
      exp_q.push_back('{data: exp_data(addr, k), id: id, beat: 8'(k), last: (k == BEATS - 1)});
    end
  endtask

  // Starts at posedge+1; returns the acceptance cycle (-1 on timeout).
  task automatic send(input logic [31:0] addr, input logic [3:0] id, output int acc);
    acc = -1;
    txreq_vld = 1'b1;
    txreq_pld = addr;
    txreq_id  = id;
    for (int n = 0; n < 200 && acc < 0; n++) begin
      @(negedge clk);
      if (txreq_rdy) begin
        acc = cyc;
        push_exp(addr, id);
      end
      @(posedge clk);
      #1;
    end
    txreq_vld = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || rxdat_vld) && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard monitor plus stall-stability check.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("vld_held_in_stall", 64'(rxdat_vld), 64'd1);
        if (rxdat_vld) begin
          tests++;
          assert (rxdat_pld === prev_pld) else begin
            fails++;
            $error("FAIL pld_stable: observed %h expected %h", rxdat_pld, prev_pld);
          end
        end
      end
      if (rxdat_vld && rxdat_rdy) begin
        hs_cyc.push_back(cyc);
        if (watch5 && rxdat_pld.txnid == 4'd5) n5++;
        check("beat_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          tests++;
          assert (rxdat_pld.data === e.data && rxdat_pld.txnid === e.id &&
                  rxdat_pld.beat === e.beat && rxdat_pld.last === e.last) else begin
            fails++;
            $error("FAIL beat: observed id=%0h beat=%0h last=%0b data=%h expected id=%0h beat=%0h last=%0b data=%h",
                   rxdat_pld.txnid, rxdat_pld.beat, rxdat_pld.last, rxdat_pld.data,
                   e.id, e.beat, e.last, e.data);
          end
        end
      end
      prev_stall = rxdat_vld && !rxdat_rdy;
      prev_pld   = rxdat_pld;
    end
  end

  initial begin
    int acc, acc5, first_pop, acc_n, rdy_hi, found;
    logic [31:0] a5 [5];
    logic [3:0]  id5 [5];

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txreq_rdy", 64'(txreq_rdy), 64'd0);
    check("rst_rxdat_vld", 64'(rxdat_vld), 64'd0);
    tests++;
    assert (rxdat_pld === '0) else begin
      fails++;
      $error("FAIL rst_pld: observed %h expected 0", rxdat_pld);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", 64'(txreq_rdy), 64'd1);
    @(posedge clk);
    #1;

    // Single request, latency and data.
    rxdat_rdy = 1'b1;
    hs_cyc.delete();
    send(32'h1000, 4'd3, acc);
    check("single_accept", 64'(acc >= 0), 64'd1);
    wait_drain("single_drain");
    check("single_nbeats", 64'(hs_cyc.size()), 64'd2);
    if (hs_cyc.size() >= 2) begin
      check("single_beat0_cyc", 64'(hs_cyc[0]), 64'(acc + LATENCY + 1));
      check("single_beat1_cyc", 64'(hs_cyc[1]), 64'(acc + LATENCY + 2));
    end

    // Five back-to-back requests against a stalled return path.
    rxdat_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a5[i]  = 32'h5000 + 32'(i * 64);
      id5[i] = 4'(10 + i);
    end
    acc_n = 0; rdy_hi = 0; first_pop = -1; acc5 = -1;
    txreq_vld = 1'b1;
    txreq_pld = a5[0];
    txreq_id  = id5[0];
    for (int n = 0; n < 300 && acc_n < 5; n++) begin
      if (n == 20) rxdat_rdy = 1'b1;
      @(negedge clk);
      if (n < 20 && txreq_rdy) rdy_hi++;
      if (rxdat_vld && rxdat_rdy && rxdat_pld.last && first_pop < 0) begin
        first_pop = cyc;
        check("full_pop_rdy_low", 64'(txreq_rdy), 64'd0);
      end
      if (txreq_rdy) begin
        push_exp(a5[acc_n], id5[acc_n]);
        if (acc_n == 4) acc5 = cyc;
        acc_n++;
      end
      @(posedge clk);
      #1;
      if (acc_n < 5) begin
        txreq_pld = a5[acc_n];
        txreq_id  = id5[acc_n];
      end else begin
        txreq_vld = 1'b0;
      end
    end
    txreq_vld = 1'b0;
    check("full_accepted_first", 64'(rdy_hi), 64'd4);
    check("full_all_accepted", 64'(acc_n), 64'd5);
    check("fifth_after_pop", 64'(acc5), 64'(first_pop + 1));
    wait_drain("full_drain");

    // Back-pressure 1,0,0,1 during a response.
    rxdat_rdy = 1'b0;
    hs_cyc.delete();
    send(32'h2040, 4'd7, acc);
    found = 0;
    for (int n = 0; n < 50 && found == 0; n++) begin
      @(negedge clk);
      if (rxdat_vld) found = 1;
    end
    check("bp_vld_seen", 64'(found), 64'd1);
    @(posedge clk); #1 rxdat_rdy = 1'b1;
    @(posedge clk); #1 rxdat_rdy = 1'b0;
    @(posedge clk); #1 rxdat_rdy = 1'b0;
    @(posedge clk); #1 rxdat_rdy = 1'b1;
    wait_drain("bp_drain");
    check("bp_nbeats", 64'(hs_cyc.size()), 64'd2);

    // Ids 1,2,3 on consecutive cycles: in order, no gap between lines.
    hs_cyc.delete();
    send(32'h0000_0100, 4'd1, acc);
    send(32'h0000_0200, 4'd2, acc);
    send(32'h0000_0300, 4'd3, acc);
    wait_drain("order_drain");
    check("order_nbeats", 64'(hs_cyc.size()), 64'd6);
    found = 1;
    for (int i = 0; i + 1 < hs_cyc.size(); i++) begin
      if (hs_cyc[i+1] != hs_cyc[i] + 1) found = 0;
    end
    check("order_contiguous", 64'(found), 64'd1);

    // Reset pulse right after beat0 of id 5.
    send(32'h3000, 4'd5, acc);
    found = 0;
    for (int n = 0; n < 50 && found == 0; n++) begin
      @(negedge clk);
      if (rxdat_vld && rxdat_rdy) found = 1;
    end
    check("rst_mid_beat0", 64'(found), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    watch5 = 1'b1;
    @(negedge clk);
    check("rst_mid_rdy", 64'(txreq_rdy), 64'd0);
    check("rst_mid_vld", 64'(rxdat_vld), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_rdy_after", 64'(txreq_rdy), 64'd1);
    @(posedge clk);
    #1;
    send(32'h4000, 4'd9, acc);
    check("post_rst_accept", 64'(acc >= 0), 64'd1);
    wait_drain("post_rst_drain");
    repeat (20) @(posedge clk);
    check("no_id5_after_rst", 64'(n5), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
